program_sequencer_stack: RTL and testbench

//  Parametrised next-generation program sequencer for the microcontroller core.

---
 rtl/program_sequencer_stack_pkg.sv | 27 ++
 rtl/program_sequencer_stack_if.sv | 37 +++
 rtl/program_sequencer_stack_return_stack.sv | 57 +++++
 rtl/program_sequencer_stack.sv | 106 ++++++++++
 tb/tb_program_sequencer_stack.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/program_sequencer_stack_pkg.sv
// Shared widths, pm_addr source encoding and sizing helpers for the program sequencer.
package program_sequencer_stack_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned JMP_W_DEF       = 4;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam int unsigned RPT_W_DEF       = 2;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_RET,
    SRC_CALL,
    SRC_JMP,
    SRC_SEQ
  } pm_src_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/program_sequencer_stack_if.sv
// Control/status bundle between the instruction decoder and the program sequencer.
interface program_sequencer_stack_if
  import program_sequencer_stack_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned JMP_W       = JMP_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned RPT_W       = RPT_W_DEF
);
  localparam int unsigned SP_W = sp_width(STACK_DEPTH);

  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic              call;
  logic              ret;
  logic              rpt;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [JMP_W-1:0]  jmp_addr;
  logic [ADDR_W-1:0] pm_addr;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output jmp, jmp_nz, dont_jmp, call, ret, rpt, rpt_cnt, jmp_addr,
    input  pm_addr, pc, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  jmp, jmp_nz, dont_jmp, call, ret, rpt, rpt_cnt, jmp_addr,
    output pm_addr, pc, sp, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/program_sequencer_stack_return_stack.sv
// Return-address LIFO: register array indexed by occupancy; push/pop are never both set.
module program_sequencer_stack_return_stack
  import program_sequencer_stack_pkg::*;
#(
  parameter int unsigned DEPTH  = STACK_DEPTH_DEF,
  parameter int unsigned DATA_W = ADDR_W_DEF,
  parameter int unsigned SP_W   = sp_width(DEPTH)
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);
  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic [DATA_W-1:0] stack_q [DEPTH];
  logic [DATA_W-1:0] stack_d [DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    if (push) begin
      stack_d[wr_idx] = push_data;
      sp_d            = sp_q + SP_W'(1);
    end else if (pop) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end

  assign top   = stack_q[rd_idx];
  assign sp    = sp_q;
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer: pc register, counted repeat hold, sticky stack error and the
// prioritised pm_addr mux feeding program memory.
module program_sequencer_stack
  import program_sequencer_stack_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned JMP_W       = JMP_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned RPT_W       = RPT_W_DEF
) (
  input logic                      clk,
  input logic                      sync_reset,
  program_sequencer_stack_if.slave bus
);
  localparam int unsigned SP_W = sp_width(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [RPT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pm_addr_c;
  logic [SP_W-1:0]   sp;
  logic              full, empty, push, pop, hold_active;
  pm_src_e           src;

  assign pc_inc      = ADDR_W'(pc_q + ADDR_W'(1));
  assign target      = ADDR_W'(bus.jmp_addr) << (ADDR_W - JMP_W);
  assign hold_active = (hold_cnt_q != '0);

  // Source select: reset, hold, ret, call, jump, then sequential fetch.
  always_comb begin
    src = SRC_SEQ;
    if (sync_reset)                              src = SRC_RESET;
    else if (hold_active)                        src = SRC_HOLD;
    else if (bus.ret)                            src = SRC_RET;
    else if (bus.call)                           src = SRC_CALL;
    else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) src = SRC_JMP;
  end

  always_comb begin
    pm_addr_c  = pc_inc;
    push       = 1'b0;
    pop        = 1'b0;
    err_d      = err_q;
    hold_cnt_d = '0;
    case (src)
      SRC_RESET: pm_addr_c = '0;
      SRC_HOLD:  pm_addr_c = pc_q;
      SRC_RET: begin
        pm_addr_c = empty ? pc_inc : stack_top;
        pop       = !empty;
        err_d     = err_q | empty;
      end
      SRC_CALL: begin
        pm_addr_c = target;
        push      = !full;
        err_d     = err_q | full;
      end
      SRC_JMP:  pm_addr_c = target;
      default:  pm_addr_c = pc_inc;
    endcase
    // A hold in progress counts down; otherwise rpt arms it for the next instruction.
    if (hold_active)  hold_cnt_d = hold_cnt_q - RPT_W'(1);
    else if (bus.rpt) hold_cnt_d = bus.rpt_cnt;
    pc_d = pm_addr_c;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q       <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
    end
  end

  program_sequencer_stack_return_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W),
    .SP_W   (SP_W)
  ) u_return_stack (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push),
    .pop        (pop),
    .push_data  (pc_inc),
    .top        (stack_top),
    .sp         (sp),
    .full       (full),
    .empty      (empty)
  );

  assign bus.pm_addr     = pm_addr_c;
  assign bus.pc          = pc_q;
  assign bus.sp          = sp;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed scoreboard bench for program_sequencer_stack (default parameters).
module tb_program_sequencer_stack;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_JMP  = 6'b100000;
  localparam logic [5:0] OP_JNZ  = 6'b010000;
  localparam logic [5:0] OP_DJ   = 6'b001000;
  localparam logic [5:0] OP_CALL = 6'b000100;
  localparam logic [5:0] OP_RET  = 6'b000010;
  localparam logic [5:0] OP_RPT  = 6'b000001;

  typedef struct {
    string      nm;
    logic [7:0] pm;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       err;
  } exp_t;

  logic clk;
  logic sync_reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  program_sequencer_stack_if bus ();

  program_sequencer_stack dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %h expected %h", nm, fld, got, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-period.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "pm_addr",     bus.pm_addr,           e.pm);
      chk(e.nm, "pc",          bus.pc,                e.pc);
      chk(e.nm, "sp",          8'(bus.sp),            8'(e.sp));
      chk(e.nm, "stack_err",   8'(bus.stack_err),     8'(e.err));
      chk(e.nm, "stack_full",  8'(bus.stack_full),    8'(e.sp == 3'd4));
      chk(e.nm, "stack_empty", 8'(bus.stack_empty),   8'(e.sp == 3'd0));
    end
  end

  task automatic step(input string nm, input logic rst, input logic [5:0] op,
                      input logic [1:0] rc, input logic [3:0] ja,
                      input logic [7:0] epm, input logic [7:0] epc,
                      input logic [2:0] esp, input logic eerr);
    exp_t x;
    @(posedge clk);
    #1;
    sync_reset   = rst;
    bus.jmp      = op[5];
    bus.jmp_nz   = op[4];
    bus.dont_jmp = op[3];
    bus.call     = op[2];
    bus.ret      = op[1];
    bus.rpt      = op[0];
    bus.rpt_cnt  = rc;
    bus.jmp_addr = ja;
    x.nm = nm; x.pm = epm; x.pc = epc; x.sp = esp; x.err = eerr;
    sb.push_back(x);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    sync_reset   = 1'b1;
    bus.jmp      = 1'b0;
    bus.jmp_nz   = 1'b0;
    bus.dont_jmp = 1'b0;
    bus.call     = 1'b0;
    bus.ret      = 1'b0;
    bus.rpt      = 1'b0;
    bus.rpt_cnt  = '0;
    bus.jmp_addr = '0;

    // Reset and sequential fetch
    repeat (3) step("reset", 1'b1, OP_NONE, 2'd0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    step("seq0", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h01, 8'h00, 3'd0, 1'b0);
    step("seq1", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h02, 8'h01, 3'd0, 1'b0);
    step("seq2", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h03, 8'h02, 3'd0, 1'b0);
    step("seq3", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h04, 8'h03, 3'd0, 1'b0);
    step("seq4", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h05, 8'h04, 3'd0, 1'b0);

    // Jumps
    step("jmp",        1'b0, OP_JMP,          2'd0, 4'h3, 8'h30, 8'h05, 3'd0, 1'b0);
    step("jnz_nottkn", 1'b0, OP_JNZ | OP_DJ,  2'd0, 4'h3, 8'h31, 8'h30, 3'd0, 1'b0);
    step("jnz_taken",  1'b0, OP_JNZ,          2'd0, 4'h3, 8'h30, 8'h31, 3'd0, 1'b0);
    step("jmp_f0",     1'b0, OP_JMP,          2'd0, 4'hF, 8'hF0, 8'h30, 3'd0, 1'b0);
    for (int i = 0; i < 16; i++)
      step("wrap", 1'b0, OP_NONE, 2'd0, 4'h0, 8'(8'hF0 + i + 1), 8'(8'hF0 + i), 3'd0, 1'b0);

    // Single call / return
    step("jmp_10",  1'b0, OP_JMP,  2'd0, 4'h1, 8'h10, 8'h00, 3'd0, 1'b0);
    step("call",    1'b0, OP_CALL, 2'd0, 4'h4, 8'h40, 8'h10, 3'd0, 1'b0);
    step("in_sub",  1'b0, OP_NONE, 2'd0, 4'h0, 8'h41, 8'h40, 3'd1, 1'b0);
    step("ret",     1'b0, OP_RET,  2'd0, 4'h0, 8'h11, 8'h41, 3'd1, 1'b0);
    step("after_r", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h12, 8'h11, 3'd0, 1'b0);

    // Nested calls past the stack depth, then unwind past empty
    step("ncall1",  1'b0, OP_CALL, 2'd0, 4'h1, 8'h10, 8'h12, 3'd0, 1'b0);
    step("ncall2",  1'b0, OP_CALL, 2'd0, 4'h2, 8'h20, 8'h10, 3'd1, 1'b0);
    step("ncall3",  1'b0, OP_CALL, 2'd0, 4'h3, 8'h30, 8'h20, 3'd2, 1'b0);
    step("ncall4",  1'b0, OP_CALL, 2'd0, 4'h5, 8'h50, 8'h30, 3'd3, 1'b0);
    step("ncall5",  1'b0, OP_CALL, 2'd0, 4'h6, 8'h60, 8'h50, 3'd4, 1'b0);
    step("nret1",   1'b0, OP_RET,  2'd0, 4'h0, 8'h31, 8'h60, 3'd4, 1'b1);
    step("nret2",   1'b0, OP_RET,  2'd0, 4'h0, 8'h21, 8'h31, 3'd3, 1'b1);
    step("nret3",   1'b0, OP_RET,  2'd0, 4'h0, 8'h11, 8'h21, 3'd2, 1'b1);
    step("nret4",   1'b0, OP_RET,  2'd0, 4'h0, 8'h13, 8'h11, 3'd1, 1'b1);
    step("nret5",   1'b0, OP_RET,  2'd0, 4'h0, 8'h14, 8'h13, 3'd0, 1'b1);
    step("callret", 1'b0, OP_CALL | OP_RET | OP_JMP, 2'd0, 4'h9, 8'h15, 8'h14, 3'd0, 1'b1);
    step("no_push", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h16, 8'h15, 3'd0, 1'b1);

    // Counted repeat; control ops ignored while holding
    step("jmp_20",  1'b0, OP_JMP,  2'd0, 4'h2, 8'h20, 8'h16, 3'd0, 1'b1);
    step("rpt3",    1'b0, OP_RPT,  2'd3, 4'h0, 8'h21, 8'h20, 3'd0, 1'b1);
    step("hold_j",  1'b0, OP_JMP,  2'd0, 4'h5, 8'h21, 8'h21, 3'd0, 1'b1);
    step("hold2",   1'b0, OP_NONE, 2'd0, 4'h0, 8'h21, 8'h21, 3'd0, 1'b1);
    step("hold_c",  1'b0, OP_CALL, 2'd0, 4'h7, 8'h21, 8'h21, 3'd0, 1'b1);
    step("hold_x",  1'b0, OP_NONE, 2'd0, 4'h0, 8'h22, 8'h21, 3'd0, 1'b1);
    step("post_h",  1'b0, OP_NONE, 2'd0, 4'h0, 8'h23, 8'h22, 3'd0, 1'b1);
    step("rpt0",    1'b0, OP_RPT,  2'd0, 4'h0, 8'h24, 8'h23, 3'd0, 1'b1);
    step("rpt0_nx", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h25, 8'h24, 3'd0, 1'b1);

    // Reset in the middle of a hold with two stacked returns
    step("rc1",     1'b0, OP_CALL, 2'd0, 4'h4, 8'h40, 8'h25, 3'd0, 1'b1);
    step("rc2",     1'b0, OP_CALL, 2'd0, 4'h5, 8'h50, 8'h40, 3'd1, 1'b1);
    step("rrpt",    1'b0, OP_RPT,  2'd3, 4'h0, 8'h51, 8'h50, 3'd2, 1'b1);
    step("rhold",   1'b0, OP_NONE, 2'd0, 4'h0, 8'h51, 8'h51, 3'd2, 1'b1);
    step("rst_mid", 1'b1, OP_NONE, 2'd0, 4'h0, 8'h00, 8'h51, 3'd2, 1'b1);
    step("post_r0", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h01, 8'h00, 3'd0, 1'b0);
    step("post_r1", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h02, 8'h01, 3'd0, 1'b0);
    step("uflow",   1'b0, OP_RET,  2'd0, 4'h0, 8'h03, 8'h02, 3'd0, 1'b0);
    step("uflow_e", 1'b0, OP_NONE, 2'd0, 4'h0, 8'h04, 8'h03, 3'd1 - 3'd1, 1'b1);

    for (int n = 0; n < 10 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
